// File: rtl/fetch_hazard_ctrl_if.sv
// Hazard-source inputs and fetch/IF-ID control outputs of the fetch sequencer.
interface fetch_hazard_ctrl_if;
  logic        load_use_d;
  logic        jump_d;
  logic        redirect_e;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  state_o;
  logic        timeout_err;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output load_use_d, jump_d, redirect_e,
    input  pc_en, pc_sel, ifid_en, ifid_flush, idex_flush,
    input  state_o, timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  load_use_d, jump_d, redirect_e,
    output pc_en, pc_sel, ifid_en, ifid_flush, idex_flush,
    output state_o, timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage / IF-ID sequencer: load-use stall, jump hold and execute redirect via one FSM.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush performance counters.
module fetch_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALL   = 1,
  parameter int RES_TIMEOUT  = 3
) (
  input logic             clk,
  input logic             rst,
  fetch_hazard_ctrl_if.slave hz
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : gBadFlush
    $error("FLUSH_CYCLES out of range 1..7");
  end
  if (LOAD_STALL < 1 || LOAD_STALL > 7) begin : gBadStall
    $error("LOAD_STALL out of range 1..7");
  end
  if (RES_TIMEOUT < 1 || RES_TIMEOUT > 15) begin : gBadTimeout
    $error("RES_TIMEOUT out of range 1..15");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    WAIT_RES = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t      state, stateNext;
  logic [3:0]  cnt, cntNext, cntDec;
  logic        timeoutErr, timeoutSet;
  logic        pcEn, ifidEn, ifidFlush, idexFlush;
  logic [1:0]  pcSel;

  assign cntDec = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      cnt        <= 4'd0;
      timeoutErr <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (timeoutSet) timeoutErr <= 1'b1;
    end
  end

  // STALL and FLUSH count the detection cycle as the first frozen/bubble cycle,
  // so they leave when the decremented count reaches zero.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    timeoutSet = 1'b0;
    pcEn       = 1'b1;
    pcSel      = 2'b00;
    ifidEn     = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    if (hz.redirect_e) begin
      pcSel     = 2'b01;
      ifidEn    = 1'b0;
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        stateNext = FLUSH;
        cntNext   = 4'(FLUSH_CYCLES - 1);
      end else begin
        stateNext = RUN;
        cntNext   = 4'd0;
      end
    end else begin
      case (state)
        RUN: begin
          if (hz.jump_d) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            ifidFlush = 1'b1;
            stateNext = WAIT_RES;
            cntNext   = 4'(RES_TIMEOUT - 1);
          end else if (hz.load_use_d) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
            if (LOAD_STALL > 1) begin
              stateNext = STALL;
              cntNext   = 4'(LOAD_STALL - 1);
            end
          end
        end
        STALL: begin
          pcEn      = 1'b0;
          ifidEn    = 1'b0;
          idexFlush = 1'b1;
          cntNext   = cntDec;
          if (cnt <= 4'd1) stateNext = RUN;
        end
        WAIT_RES: begin
          pcEn      = 1'b0;
          ifidEn    = 1'b0;
          ifidFlush = 1'b1;
          if (cnt == 4'd0) begin
            stateNext  = RUN;
            timeoutSet = 1'b1;
          end else begin
            cntNext = cntDec;
          end
        end
        FLUSH: begin
          ifidEn    = 1'b0;
          ifidFlush = 1'b1;
          cntNext   = cntDec;
          if (cnt <= 4'd1) stateNext = RUN;
        end
        default: stateNext = RUN;
      endcase
    end
  end

  // Reset holds the front end frozen and bubbled regardless of state.
  assign hz.pc_en       = rst & pcEn;
  assign hz.pc_sel      = rst ? pcSel : 2'b00;
  assign hz.ifid_en     = rst & ifidEn;
  assign hz.ifid_flush  = ~rst | ifidFlush;
  assign hz.idex_flush  = ~rst | idexFlush;
  assign hz.state_o     = state;
  assign hz.timeout_err = timeoutErr;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stallCnt, flushCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= 16'h0000;
      flushCnt <= 16'h0000;
    end else begin
      if (!pcEn && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
      if (ifidFlush && flushCnt != 16'hFFFF) flushCnt <= flushCnt + 16'd1;
    end
  end

  assign hz.stall_cnt = stallCnt;
  assign hz.flush_cnt = flushCnt;
`else
  assign hz.stall_cnt = 16'h0000;
  assign hz.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: directed scenarios plus random traffic vs. a duration-based model.
module tb_fetch_hazard_ctrl;
  localparam int FC = 2;
  localparam int LS = 2;
  localparam int RT = 3;
  localparam int K_RUN = 0, K_STALL = 1, K_WAIT = 2, K_FLUSH = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Model: current phase and how many cycles of it remain.
  int   mKind, mLeft;
  bit   mTerr;
  int   mStall, mFlush;

  fetch_hazard_ctrl_if hzIf ();

  fetch_hazard_ctrl #(.FLUSH_CYCLES(FC), .LOAD_STALL(LS), .RES_TIMEOUT(RT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hzIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOuts(input string tag, input bit ePc, input logic [1:0] eSel,
                           input bit eIfEn, input bit eIfFl, input bit eIdFl);
    chk({tag, ".pc_en"},       16'(hzIf.pc_en),       16'(ePc));
    chk({tag, ".pc_sel"},      16'(hzIf.pc_sel),      16'(eSel));
    chk({tag, ".ifid_en"},     16'(hzIf.ifid_en),     16'(eIfEn));
    chk({tag, ".ifid_flush"},  16'(hzIf.ifid_flush),  16'(eIfFl));
    chk({tag, ".idex_flush"},  16'(hzIf.idex_flush),  16'(eIdFl));
    chk({tag, ".state_o"},     16'(hzIf.state_o),     16'(mKind));
    chk({tag, ".timeout_err"}, 16'(hzIf.timeout_err), 16'(mTerr));
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".stall_cnt"},   hzIf.stall_cnt,        16'(mStall));
    chk({tag, ".flush_cnt"},   hzIf.flush_cnt,        16'(mFlush));
`else
    chk({tag, ".stall_cnt"},   hzIf.stall_cnt,        16'h0000);
    chk({tag, ".flush_cnt"},   hzIf.flush_cnt,        16'h0000);
`endif
  endtask

  task automatic modelReset();
    mKind  = K_RUN;
    mLeft  = 0;
    mTerr  = 1'b0;
    mStall = 0;
    mFlush = 0;
  endtask

  // Called at posedge+1; drives inputs, checks mid-cycle, then advances the model and the clock.
  task automatic cycle(input string tag, input bit l, input bit j, input bit r);
    bit ePc, eIfEn, eIfFl, eIdFl;
    logic [1:0] eSel;
    hzIf.load_use_d = l;
    hzIf.jump_d     = j;
    hzIf.redirect_e = r;
    ePc = 1; eSel = 2'b00; eIfEn = 1; eIfFl = 0; eIdFl = 0;
    if (r) begin
      eSel = 2'b01; eIfEn = 0; eIfFl = 1; eIdFl = 1;
    end else if (mKind == K_RUN && j) begin
      ePc = 0; eIfEn = 0; eIfFl = 1;
    end else if (mKind == K_RUN && l) begin
      ePc = 0; eIfEn = 0; eIdFl = 1;
    end else if (mKind == K_STALL) begin
      ePc = 0; eIfEn = 0; eIdFl = 1;
    end else if (mKind == K_WAIT) begin
      ePc = 0; eIfEn = 0; eIfFl = 1;
    end else if (mKind == K_FLUSH) begin
      eIfEn = 0; eIfFl = 1;
    end
    #3;
    checkOuts(tag, ePc, eSel, eIfEn, eIfFl, eIdFl);
    if (!ePc && mStall < 16'hFFFF) mStall++;
    if (eIfFl && mFlush < 16'hFFFF) mFlush++;
    if (r) begin
      if (FC > 1) begin mKind = K_FLUSH; mLeft = FC - 1; end
      else mKind = K_RUN;
    end else begin
      case (mKind)
        K_RUN: begin
          if (j) begin mKind = K_WAIT; mLeft = RT; end
          else if (l && LS > 1) begin mKind = K_STALL; mLeft = LS - 1; end
        end
        K_WAIT: begin
          mLeft--;
          if (mLeft == 0) begin mKind = K_RUN; mTerr = 1'b1; end
        end
        default: begin
          mLeft--;
          if (mLeft == 0) mKind = K_RUN;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, checks the forced outputs, releases after an edge.
  task automatic resetPulse(input string tag);
    hzIf.load_use_d = 0;
    hzIf.jump_d     = 0;
    hzIf.redirect_e = 0;
    rst = 1'b0;
    #1;
    modelReset();
    checkOuts(tag, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    hzIf.load_use_d = 0;
    hzIf.jump_d     = 0;
    hzIf.redirect_e = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkOuts("por", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle("run0", 0, 0, 0);

    // Load-use stall
    cycle("lu_det", 1, 0, 0);
    repeat (3) cycle("lu_after", 0, 0, 0);

    // Redirect from RUN
    cycle("rd_det", 0, 0, 1);
    repeat (3) cycle("rd_after", 0, 0, 0);

    // Jump hold resolved by redirect two cycles later
    cycle("jr_jump", 0, 1, 0);
    cycle("jr_wait", 0, 0, 0);
    cycle("jr_redir", 0, 0, 1);
    repeat (3) cycle("jr_after", 0, 0, 0);

    // Jump hold timing out; jump/load-use ignored while waiting
    cycle("to_jump", 0, 1, 0);
    cycle("to_wait", 1, 1, 0);
    repeat (6) cycle("to_after", 0, 0, 0);
    chk("to_sticky", 16'(hzIf.timeout_err), 16'd1);

    // Reset in the middle of FLUSH
    cycle("mf_redir", 0, 0, 1);
    resetPulse("mf_reset");
    cycle("mf_run", 0, 0, 0);
    chk("mf_state", 16'(hzIf.state_o), 16'd0);

    // Redirect beats a simultaneous load-use
    cycle("rl_both", 1, 0, 1);
    repeat (3) cycle("rl_after", 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rl_flush_cnt", hzIf.flush_cnt, 16'(FC));
    chk("rl_stall_cnt", hzIf.stall_cnt, 16'd0);
`else
    chk("rl_flush_cnt", hzIf.flush_cnt, 16'd0);
    chk("rl_stall_cnt", hzIf.stall_cnt, 16'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) resetPulse("rnd_reset");
      else cycle("rnd", ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
